// File: rtl/fpu_scheduler.sv
// Two-requester round-robin scheduler for a shared fixed-point unit (IDLE/ISSUE/WAIT/RESP).
// Define FPU_SCHED_TIMEOUT_EN to abort a WAIT that reaches TIMEOUT cycles with rsp_error.
module fpu_scheduler #(
   parameter int WIDTH    = 32,
   parameter int MUL_WAIT = 6,
   parameter int TIMEOUT  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_valid,
   input  logic [3:0]         req_op,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   output logic [1:0]         req_ready,
   output logic [1:0]         rsp_valid,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_error,
   output logic [1:0]         fpu_operation,
   output logic [WIDTH-1:0]   fpu_operand_1,
   output logic [WIDTH-1:0]   fpu_operand_2,
   input  logic [WIDTH-1:0]   fpu_result,
   input  logic               fpu_ready
);

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam int CNT_MAX = (MUL_WAIT > TIMEOUT) ? MUL_WAIT : TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_owner;
   logic             r_last;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [CW-1:0]    r_cnt;
   logic             w_win;
   logic             w_grant;
   logic             w_ready_ok;
   logic             w_accept;
   logic             w_done;

   // With both requesters pending the one not served last wins.
   assign w_win   = (&req_valid) ? ~r_last : req_valid[1];
   assign w_grant = (r_state == S_IDLE) && (|req_valid) && !reset;

   // Ready is masked early in WAIT so a flag left high by the previous op is not taken.
   assign w_ready_ok = (r_op == FPU_MUL) ? (r_cnt >= CW'(MUL_WAIT)) : (r_cnt >= CW'(2));
   assign w_accept   = (r_state == S_WAIT) && w_ready_ok && fpu_ready;

`ifdef FPU_SCHED_TIMEOUT_EN
   logic r_err;
   logic w_timeout;
   assign w_timeout = (r_state == S_WAIT) && !w_accept && (r_cnt >= CW'(TIMEOUT));
   assign w_done    = w_accept || w_timeout;
   assign rsp_error = (r_state == S_RESP) && r_err;
`else
   assign w_done    = w_accept;
   assign rsp_error = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      req_ready    = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               req_ready    = w_win ? 2'b10 : 2'b01;
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: w_state_next = r_op[1] ? S_WAIT : S_RESP;
         S_WAIT:  if (w_done) w_state_next = S_RESP;
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign rsp_valid     = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data      = (r_state == S_RESP) ? r_result : '0;
   assign fpu_operation = (r_state == S_IDLE) ? FPU_ADD : r_op;
   assign fpu_operand_1 = (r_state == S_IDLE) ? '0 : r_a;
   assign fpu_operand_2 = (r_state == S_IDLE) ? '0 : r_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;
         r_op     <= FPU_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cnt    <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
         r_err    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_owner <= w_win;
                  r_last  <= w_win;
                  r_op    <= w_win ? req_op[3:2] : req_op[1:0];
                  r_a     <= w_win ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                  r_b     <= w_win ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
`ifdef FPU_SCHED_TIMEOUT_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            S_ISSUE: begin
               if (!r_op[1]) r_result <= fpu_result;
               r_cnt <= CW'(1);
            end
            S_WAIT: begin
               if (w_accept) begin
                  r_result <= fpu_result;
`ifdef FPU_SCHED_TIMEOUT_EN
               end else if (w_timeout) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
`endif
               end
               if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
            end
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed bench for fpu_scheduler with a behavioural fixed-point unit (FBITS=10).
// Timeout scenario runs when FPU_SCHED_TIMEOUT_EN is defined, otherwise the indefinite wait.
module tb_fpu_scheduler;
   localparam int WIDTH = 32;
   localparam int MUL_WAIT = 6;
   localparam int TIMEOUT = 8;

   logic clk = 0;
   logic reset = 1;
   logic [1:0] req_valid = 0;
   logic [3:0] req_op = 0;
   logic [2*WIDTH-1:0] req_a = 0, req_b = 0;
   logic [1:0] req_ready, rsp_valid, fpu_operation;
   logic [WIDTH-1:0] rsp_data, fpu_operand_1, fpu_operand_2, fpu_result;
   logic rsp_error;
   logic fpu_ready = 0;
   logic [63:0] prod;
   int checks = 0, failures = 0, lat, seen;

   always #5 clk = ~clk;

   fpu_scheduler #(.WIDTH(WIDTH), .MUL_WAIT(MUL_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_error(rsp_error), .fpu_operation(fpu_operation),
      .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
      .fpu_result(fpu_result), .fpu_ready(fpu_ready));

   // Shared unit model: ADD, SUB, MUL in Q.10, SQRT returns a fixed marker value.
   assign prod = 64'(fpu_operand_1) * 64'(fpu_operand_2);
   assign fpu_result = (fpu_operation == 2'd0) ? fpu_operand_1 + fpu_operand_2 :
                       (fpu_operation == 2'd1) ? fpu_operand_1 - fpu_operand_2 :
                       (fpu_operation == 2'd2) ? prod[WIDTH+9:10] : 32'h5A5;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the grant cycle; returns cycles from grant to rsp_valid (100 = never).
   task automatic wait_rsp(output int l);
      l = 100;
      for (int c = 1; c < 100; c++) begin
         tick();
         req_valid = 2'b00;
         if (rsp_valid != 2'b00) begin
            l = c;
            break;
         end
      end
   endtask

   task automatic set_req0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[1:0] = op;
      req_a[31:0] = a;
      req_b[31:0] = b;
   endtask

   initial begin
      // Reset values while held
      #12;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_error", rsp_error, 1'b0);
      chk("rst_fpu_op", fpu_operation, 2'd0);
      chk("rst_operands", {fpu_operand_1, fpu_operand_2}, 0);
      tick();
      reset = 0;

      // Single ADD from requester 0: 0x400 + 0x800
      set_req0(2'd0, 32'h400, 32'h800);
      req_valid = 2'b01;
      #1;
      chk("add_grant", req_ready, 2'b01);
      chk("add_idle_op1", fpu_operand_1, 0);
      tick();
      req_valid = 2'b00;
      chk("add_issue_op1", fpu_operand_1, 32'h400);
      chk("add_issue_op2", fpu_operand_2, 32'h800);
      chk("add_issue_noready", req_ready, 2'b00);
      chk("add_issue_norsp", rsp_valid, 2'b00);
      tick();
      chk("add_rsp_valid", rsp_valid, 2'b01);
      chk("add_rsp_data", rsp_data, 32'hC00);
      chk("add_rsp_error", rsp_error, 1'b0);
      tick();
      chk("add_back_idle", rsp_valid, 2'b00);

      // Round robin after reset: requester 0 first, then alternate
      reset = 1;
      tick();
      reset = 0;
      set_req0(2'd0, 32'h100, 32'h200);
      req_op[3:2] = 2'd1;
      req_a[63:32] = 32'h900;
      req_b[63:32] = 32'h100;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
         tick();
         chk($sformatf("rr_issue_ready%0d", k), req_ready, 2'b00);
         tick();
         chk($sformatf("rr_rsp_valid%0d", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
         chk($sformatf("rr_rsp_data%0d", k), rsp_data, (k % 2) ? 32'h800 : 32'h300);
         chk($sformatf("rr_rsp_ready%0d", k), req_ready, 2'b00);
         tick();
      end
      req_valid = 2'b00;
      tick();

      // MUL 2.0*3.0 with a stale ready held high; result in 8 cycles
      fpu_ready = 1;
      set_req0(2'd2, 32'h800, 32'hC00);
      req_valid = 2'b01;
      #1;
      chk("mul_grant", req_ready, 2'b01);
      wait_rsp(lat);
      chk("mul_latency", lat, MUL_WAIT + 2);
      chk("mul_rsp_valid", rsp_valid, 2'b01);
      chk("mul_rsp_data", rsp_data, 32'h1800);
      tick();

      // SQRT with stale ready: masked for one WAIT cycle
      set_req0(2'd3, 32'h1000, 32'h0);
      req_valid = 2'b01;
      #1;
      chk("sqrt_grant", req_ready, 2'b01);
      wait_rsp(lat);
      chk("sqrt_latency", lat, 4);
      chk("sqrt_rsp_data", rsp_data, 32'h5A5);
      tick();

      // Reset during WAIT drops the MUL with no response
      fpu_ready = 0;
      set_req0(2'd2, 32'h800, 32'h800);
      req_valid = 2'b01;
      #1;
      chk("rw_grant", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("rw_in_wait_op", fpu_operation, 2'd2);
      #2;
      reset = 1;
      #1;
      chk("rw_fpu_op", fpu_operation, 2'd0);
      chk("rw_operands", {fpu_operand_1, fpu_operand_2}, 0);
      chk("rw_outs", {req_ready, rsp_valid, rsp_error}, 0);
      chk("rw_rsp_data", rsp_data, 0);
      fpu_ready = 1;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (rsp_valid != 2'b00) seen++;
      end
      chk("rw_no_rsp", seen, 0);
      reset = 0;
      fpu_ready = 0;
      req_op[3:2] = 2'd0;
      req_a[63:32] = 32'h100;
      req_b[63:32] = 32'h200;
      req_valid = 2'b10;
      #1;
      chk("rw_new_grant", req_ready, 2'b10);
      wait_rsp(lat);
      chk("rw_new_latency", lat, 2);
      chk("rw_new_rsp_valid", rsp_valid, 2'b10);
      chk("rw_new_data", rsp_data, 32'h300);
      tick();

      // MUL with fpu_ready held low
      set_req0(2'd2, 32'h800, 32'hC00);
      req_valid = 2'b01;
      #1;
      chk("to_grant", req_ready, 2'b01);
`ifdef FPU_SCHED_TIMEOUT_EN
      wait_rsp(lat);
      chk("to_latency", lat, TIMEOUT + 2);
      chk("to_rsp_valid", rsp_valid, 2'b01);
      chk("to_rsp_error", rsp_error, 1'b1);
      chk("to_rsp_data", rsp_data, 0);
`else
      seen = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         req_valid = 2'b00;
         if (rsp_valid != 2'b00) seen++;
      end
      chk("nto_no_rsp", seen, 0);
      fpu_ready = 1;
      wait_rsp(lat);
      chk("nto_latency", lat, 1);
      chk("nto_rsp_valid", rsp_valid, 2'b01);
      chk("nto_rsp_error", rsp_error, 1'b0);
      chk("nto_rsp_data", rsp_data, 32'h1800);
`endif
      tick();
      chk("end_idle", rsp_valid, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
